// File: rtl/instr_memory_ctrl_if.sv
// Load/fetch bus between the program loader / fetch stage and instr_memory_ctrl.
// The master drives load and fetch requests. The slave returns fetched words and status.
interface instr_memory_ctrl_if #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
);
  logic                   load_start;
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_done;
  logic                   fetch_en;
  logic [ADDR_WIDTH-1:0]  program_counter;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic                   instr_stop;
  logic [ADDR_WIDTH:0]    prog_len;
  logic                   load_overflow;
  logic [1:0]             state;

  modport master (
    output load_start, load_valid, load_data, load_done, fetch_en, program_counter,
    input  instruction, instr_valid, instr_stop, prog_len, load_overflow, state
  );

  modport slave (
    input  load_start, load_valid, load_data, load_done, fetch_en, program_counter,
    output instruction, instr_valid, instr_stop, prog_len, load_overflow, state
  );
endinterface

// File: rtl/instr_memory_ctrl.sv
// Instruction memory: a sequential program-load port and a registered fetch port.
// The recorded program length gates every fetch and drives the processor stop flag.
module instr_memory_ctrl #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 2 ** ADDR_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  instr_memory_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = (ADDR_WIDTH + 1)'(1);

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [ADDR_WIDTH:0]    prog_len_q, prog_len_d;
  logic                   overflow_q;
  logic [INSTR_WIDTH-1:0] instruction_q;
  logic                   instr_valid_q;
  logic                   instr_stop_q;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

  logic                   load_accept;
  logic                   load_drop;
  logic [ADDR_WIDTH:0]    pc_ext;
  logic                   fetch_hit;
  logic                   fetch_last;

  always_comb begin
    load_accept = 1'b0;
    load_drop   = 1'b0;
    if (state_q == LOAD && !bus.load_start && bus.load_valid) begin
      load_accept = (prog_len_q < FULL_LEN);
      load_drop   = (prog_len_q >= FULL_LEN);
    end
    wr_ptr_d   = load_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    prog_len_d = load_accept ? prog_len_q + LEN_ONE : prog_len_q;
    // pc+1 is formed one bit wider so the last word of a full memory stops instead of wrapping
    pc_ext     = {1'b0, bus.program_counter};
    fetch_hit  = (pc_ext < prog_len_q);
    fetch_last = ((pc_ext + LEN_ONE) >= prog_len_q);
  end

  // Memory array has no reset; stale words stay hidden behind prog_len.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem_q[wr_ptr_q] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      instruction_q <= '0;
      instr_valid_q <= 1'b0;
      instr_stop_q  <= 1'b0;
    end else if (bus.load_start) begin
      state_q       <= LOAD;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      overflow_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_stop_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      if (load_drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          instr_valid_q <= 1'b0;
        end
        LOAD: begin
          instr_valid_q <= 1'b0;
          // Length after any same-cycle write decides between RUN and an empty program
          if (bus.load_done) begin
            state_q <= (prog_len_d != '0) ? RUN : IDLE;
          end
        end
        RUN: begin
          if (bus.fetch_en) begin
            if (fetch_hit) begin
              instruction_q <= mem_q[bus.program_counter];
              instr_valid_q <= 1'b1;
              instr_stop_q  <= fetch_last;
              if (fetch_last) begin
                state_q <= HALT;
              end
            end else begin
              instruction_q <= '0;
              instr_valid_q <= 1'b0;
              instr_stop_q  <= 1'b1;
              state_q       <= HALT;
            end
          end else begin
            instr_valid_q <= 1'b0;
          end
        end
        HALT: begin
          instr_valid_q <= 1'b0;
          instr_stop_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.instruction   = instruction_q;
  assign bus.instr_valid   = instr_valid_q;
  assign bus.instr_stop    = instr_stop_q;
  assign bus.prog_len      = prog_len_q;
  assign bus.load_overflow = overflow_q;
  assign bus.state         = state_q;

endmodule

// File: doc/instr_memory_ctrl.md
# instr_memory_ctrl

Parametrised, clocked instruction memory with a sequential program-load port and a registered fetch port. A program is streamed in word by word, and its length is recorded. Fetches then return registered instructions, with an explicit end-of-program flag derived from that recorded length. The block sits between the program loader and the fetch stage of the pipeline, and drives the processor-stop signal.

## Interface
- INSTR_WIDTH, 16, instruction word width in bits
- ADDR_WIDTH, 8, program-counter width
- DEPTH, 2**ADDR_WIDTH (256), number of memory words
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  begin (or restart) a program load
- load_valid  in  1  load_data is valid this cycle
- load_data  in  INSTR_WIDTH  instruction word to store
- load_done  in  1  end of program load
- fetch_en  in  1  fetch request this cycle
- program_counter  in  ADDR_WIDTH  fetch address
- instruction  out  INSTR_WIDTH  registered fetched word
- instr_valid  out  1  instruction is valid this cycle
- instr_stop  out  1  no instruction exists after the one fetched; processor stops
- prog_len  out  ADDR_WIDTH+1  number of words loaded (0..DEPTH)
- load_overflow  out  1  sticky: a load word was dropped because memory was full
- state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11

## Operation
- Reset (async, rst_n=0) sets the following; memory contents are not reset:
  - state=IDLE, instruction=0, instr_valid=0, instr_stop=0
  - prog_len=0, load_overflow=0, write pointer=0
- load_start has top priority in every state:
  - next state LOAD; write pointer=0, prog_len=0, load_overflow=0, instr_stop=0, instr_valid=0
  - load_valid in the same cycle as load_start is ignored
- IDLE: waits for load_start. fetch_en, load_valid and load_done are ignored.
- LOAD:
  - load_valid with prog_len<DEPTH: mem[wr_ptr]<=load_data, wr_ptr++, prog_len++
  - load_valid with prog_len==DEPTH: word dropped, load_overflow<=1
  - load_done: next state RUN if prog_len (after any same-cycle write) >0, else IDLE
  - load_valid and load_done in the same cycle: the word is written and counted, then the transition is taken
- RUN, fetch_en=1 with program_counter<prog_len:
  - instruction<=mem[pc], instr_valid<=1
  - instr_stop<=(pc+1 >= prog_len)
- RUN, fetch_en=1 with pc>=prog_len: instruction<=0, instr_valid<=0, instr_stop<=1
- RUN, fetch_en=0: instr_valid<=0; instruction and instr_stop hold
- RUN exit: any cycle that registers instr_stop=1 moves to HALT on the same edge.
- HALT: instr_stop held at 1, instr_valid=0, instruction holds. fetch_en and load_valid are ignored. Only load_start or reset leaves HALT.
- Width rule: pc+1 is computed in ADDR_WIDTH+1 bits. With pc=DEPTH-1 and prog_len=DEPTH, instr_stop=1 and there is no wrap to 0.
- Uninitialised or unloaded words are never returned: every access is gated by prog_len.

## Timing
- Load write: 1 cycle. A word presented in cycle N is readable by a fetch issued in cycle N+1 or later, once in RUN.
- Fetch latency: 1 cycle. A request in cycle N yields instruction, instr_valid and instr_stop valid after edge N+1.
- Throughput: one fetch per cycle, back-to-back, no stalls.
- instr_stop rises together with instr_valid on the last instruction. state reads HALT from the same edge.
- prog_len and load_overflow update on the edge that accepts or drops the word.
- Reset asserted mid-load or mid-run clears outputs immediately (asynchronously). Partially loaded memory words remain but are inaccessible, because prog_len=0.

## Test plan
- **Reset:** assert rst_n=0 mid-RUN -> all outputs 0 and state=00 immediately, without waiting for clk.
- **Load and run:** load 3 words 0x1111, 0x2222, 0x3333, pulse load_done, then fetch pc=0,1,2 back-to-back ->
  - instruction 0x1111/0x2222/0x3333 one cycle after each request, instr_valid=1 each cycle
  - instr_stop=1 only with 0x3333; state=HALT after that edge
- **Overflow:** with ADDR_WIDTH=8, stream 257 words -> prog_len=256, load_overflow=1, and the 257th word is not written. Fetch pc=255 -> word 256 returned with instr_stop=1.
- **Out of range:** after loading 2 words, fetch pc=5 -> instr_valid=0, instruction=0, instr_stop=1, state=HALT.
- **Simultaneous load_valid and load_done:** send load_valid with 0xABCD and load_done in the same cycle as the first word -> prog_len=1, state=RUN, and fetch pc=0 returns 0xABCD with instr_stop=1.
- **Restart:**
  - load_start in HALT -> state=LOAD, prog_len=0, instr_stop=0
  - load_done with zero words loaded -> state=IDLE
